alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have parameter NREG, default 4, register file entries; fixed at 4 (2-bit indices).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 instr  input  16  [15:14] op, [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] unused.
REQ-008 alu_in1, alu_in2  output  16 each  operands driven to the external ALU.
REQ-009 alu_con_sig  output  2  ALU select: 00 add, 01 mul, 10 and, 11 or.
REQ-010 alu_out  input  16  combinational ALU result.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_data  output  16  result value written to rd.
REQ-014 res_err  output  1  qualifies res_valid; 1 = illegal op, no register write.

Function
REQ-015 FSM states IDLE, EXEC, MUL, RESP.
REQ-016 IDLE: instr_ready=1; on instr_valid&instr_ready latch op/rd and read rs1/rs2 into operand registers -> EXEC (op 01 with MUL_EN -> MUL).
REQ-017 EXEC: alu_in1/alu_in2/alu_con_sig driven from operand registers; alu_out captured into res_data and written to rd at end of cycle -> RESP.
REQ-018 Add/and/or latency: res_valid asserted 2 cycles after the accepting edge.
REQ-019 RESP: res_valid=1, res_data/res_err stable until res_valid&res_ready; then -> IDLE; instr_ready=0 outside IDLE.
REQ-020 Results truncated to 16 bits; add wraps modulo 2^16; no carry/overflow reported.
REQ-021 rs1 or rs2 equal to rd of the instruction in RESP reads the already-written value (write occurs before RESP).
REQ-022 alu_con_sig SHALL equal latched op in EXEC; in other states alu_in1/alu_in2/alu_con_sig hold last values (no X).
REQ-023 Back-to-back: res handshake and next instr acceptance SHALL NOT occur in the same cycle (one IDLE cycle minimum).

Reset
REQ-024 On rst: state IDLE, all four registers 0, res_data 0, res_valid 0, res_err 0, alu_in1/alu_in2 0, alu_con_sig 00, multiplier counter 0.
REQ-025 Reset asserted mid-operation (EXEC, MUL, RESP) aborts it immediately; no register write, no result presented after release.

Configuration
REQ-026 Macro ALU_ISSUE_MUL_EN defined: op 01 runs internal shift-add multiply in MUL, 16 cycles (counter 0..15), low 16 bits of product written to rd -> RESP; latency 17 cycles accept-to-res_valid; alu_con_sig shows 01 throughout MUL.
REQ-027 Macro undefined: op 01 goes EXEC -> RESP with res_err=1, res_data=0, no register write, latency 2; no multiplier logic present.

Structure
REQ-028 Shared package alu_pkg SHALL hold op encodings (OP_ADD, OP_MUL, OP_AND, OP_OR), instruction field positions, and the FSM state enum.
REQ-029 Multiplier SHALL be sub-module alu_issue_mul (start, done, 16x16 -> 16 low), instantiated only under ALU_ISSUE_MUL_EN.
REQ-030 Register file is inline in alu_issue_ctrl; external ALU is not instantiated inside.

Verification
REQ-031 After reset, issue add r1=r0+r0 -> res_valid at cycle 2, res_data=0x0000, res_err=0.
REQ-032 Preload via ops so r1=0xFFFF, r2=0x0001; add r3=r1+r2 -> res_data=0x0000 (wrap); and r0=r1&r2 -> 0x0001; or -> 0xFFFF.
REQ-033 Hold res_ready=0 for 5 cycles in RESP -> res_valid, res_data stable, instr_ready=0; drop instr_valid pulses ignored.
REQ-034 With MUL_EN, r1=0x0003, r2=0x0005, mul r3 -> res_data=0x000F at cycle 17; r1=0x0100, r2=0x0100 -> 0x0000.
REQ-035 Without MUL_EN, mul -> res_err=1, res_data=0x0000 at cycle 2, rd unchanged on later read.
REQ-036 Assert rst during MUL cycle 8 -> all outputs reset values, subsequent read of rd returns 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: opcodes, instruction field
// positions and FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 14;
  localparam int RD_LSB  = 12;
  localparam int RS1_LSB = 10;
  localparam int RS2_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    RESP = 2'b11
  } state_t;

endpackage

// File: rtl/alu_issue_mul.sv
// Sequential shift-add multiplier, W cycles after start, low W bits of product.
// Only instantiated when ALU_ISSUE_MUL_EN is defined.
module alu_issue_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] prod
);
  localparam int CW = $clog2(W);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mcand, mplier, acc, next_acc;

  assign next_acc = acc + (mplier[0] ? mcand : '0);
  // done fires in the last step, so prod already includes the final partial term
  assign done     = busy && (cnt == CW'(W - 1));
  assign prod     = next_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= next_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(W - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU with a 4-entry register file.
// Define ALU_ISSUE_MUL_EN to run op 01 on the internal multiplier; otherwise op 01 errors.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [1:0]        alu_con_sig,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err
);

  state_t            state;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] rf [NREG];

  logic [1:0] op_in, rd_in, rs1_in, rs2_in;
  logic [7:0] unused_low;

  assign op_in      = instr[OP_LSB  +: 2];
  assign rd_in      = instr[RD_LSB  +: 2];
  assign rs1_in     = instr[RS1_LSB +: 2];
  assign rs2_in     = instr[RS2_LSB +: 2];
  assign unused_low = instr[RS2_LSB-1:0];

  assign instr_ready = (state == IDLE);
  assign res_valid   = (state == RESP);

`ifdef ALU_ISSUE_MUL_EN
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign mul_start = (state == IDLE) && instr_valid && (op_in == OP_MUL);

  alu_issue_mul #(.W(DATA_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (rf[rs1_in]),
    .b     (rf[rs2_in]),
    .done  (mul_done),
    .prod  (mul_prod)
  );
`endif

  // alu_in1/alu_in2/alu_con_sig double as the operand registers and hold between ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_con_sig <= '0;
      res_data    <= '0;
      res_err     <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          rd_q        <= rd_in;
          alu_in1     <= rf[rs1_in];
          alu_in2     <= rf[rs2_in];
          alu_con_sig <= op_in;
          res_err     <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
          state       <= (op_in == OP_MUL) ? MUL : EXEC;
`else
          state       <= EXEC;
`endif
        end
        EXEC: begin
          // op 01 only reaches EXEC when the multiplier is not built
          if (alu_con_sig == OP_MUL) begin
            res_err  <= 1'b1;
            res_data <= '0;
          end else begin
            res_data <= alu_out;
            rf[rd_q] <= alu_out;
          end
          state <= RESP;
        end
`ifdef ALU_ISSUE_MUL_EN
        MUL: if (mul_done) begin
          res_data <= mul_prod;
          rf[rd_q] <= mul_prod;
          state    <= RESP;
        end
`endif
        RESP: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: latency/result model plus directed and random ops.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [1:0]  alu_con_sig;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_err;

  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(16), .NREG(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_con_sig (alu_con_sig),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return a + b;
      2'b01:   return p[15:0];
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  // External ALU; the bench can force its result to seed registers
  always_comb alu_out = ovr_en ? ovr_val : alu_f(alu_in1, alu_in2, alu_con_sig);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: result shows up m_lat cycles after acceptance, held until taken
  logic [15:0] regs [4];
  logic        m_busy, m_err, m_wr;
  logic [1:0]  m_op, m_rd;
  logic [15:0] m_a, m_b, m_data;
  int          m_cnt, m_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) regs[i] = '0;
    end else if (m_busy) begin
      if (m_cnt >= m_lat) begin
        if (res_ready) begin
          m_busy = 1'b0;
          if (m_wr) regs[m_rd] = m_data;
        end
      end else m_cnt++;
    end else if (instr_valid) begin
      m_op = instr[15:14];
      m_rd = instr[13:12];
      m_a  = regs[instr[11:10]];
      m_b  = regs[instr[9:8]];
      if (m_op == 2'b01) begin
`ifdef ALU_ISSUE_MUL_EN
        m_data = alu_f(m_a, m_b, 2'b01); m_err = 1'b0; m_wr = 1'b1; m_lat = 17;
`else
        m_data = 16'h0; m_err = 1'b1; m_wr = 1'b0; m_lat = 2;
`endif
      end else begin
        m_data = ovr_en ? ovr_val : alu_f(m_a, m_b, m_op);
        m_err = 1'b0; m_wr = 1'b1; m_lat = 2;
      end
      m_busy = 1'b1;
      m_cnt  = 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_alu_in1", alu_in1, 0);
      chk("rst_alu_in2", alu_in2, 0);
      chk("rst_alu_con", alu_con_sig, 0);
      chk("rst_instr_ready", instr_ready, 1);
    end else begin
      chk("res_valid", res_valid, (m_busy && m_cnt >= m_lat) ? 1 : 0);
      chk("instr_ready", instr_ready, m_busy ? 0 : 1);
      if (m_busy) begin
        chk("alu_in1", alu_in1, m_a);
        chk("alu_in2", alu_in2, m_b);
        chk("alu_con_sig", alu_con_sig, m_op);
        if (m_cnt >= m_lat) begin
          chk("res_data", res_data, m_data);
          chk("res_err", res_err, m_err);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input bit oe, input logic [15:0] ov, input int hold,
                       output int lat, output logic [15:0] data, output logic err);
    instr_valid = 1'b1;
    instr       = {op, rd, rs1, rs2, 8'h00};
    ovr_en      = oe;
    ovr_val     = ov;
    lat = 0;
    do begin
      @(negedge clk);
      instr_valid = 1'b0;
      lat++;
    end while (!res_valid && lat < 40);
    if (!res_valid) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout actual=0 expected=1 at %0t", $time);
    end
    data = res_data;
    err  = res_err;
    repeat (hold) begin
      instr_valid = 1'($urandom % 2);
      instr       = 16'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    ovr_en    = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [15:0] d;
    logic        e;

    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_first_lat", lat, 2);
    chk("lit_first_data", d, 16'h0000);
    chk("lit_first_err", e, 0);

    issue(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 16'hFFFF, 0, lat, d, e);
    issue(2'b00, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0001, 0, lat, d, e);
    issue(2'b00, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_add_wrap", d, 16'h0000);
    issue(2'b10, 2'd0, 2'd1, 2'd2, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_and", d, 16'h0001);
    issue(2'b11, 2'd0, 2'd1, 2'd2, 1'b0, 16'h0, 5, lat, d, e);
    chk("lit_or_stall", d, 16'hFFFF);

    issue(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0003, 0, lat, d, e);
    issue(2'b00, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0005, 0, lat, d, e);
    issue(2'b00, 2'd3, 2'd0, 2'd0, 1'b1, 16'hABCD, 0, lat, d, e);
    issue(2'b01, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 1, lat, d, e);
`ifdef ALU_ISSUE_MUL_EN
    chk("lit_mul_lat", lat, 17);
    chk("lit_mul_data", d, 16'h000F);
    chk("lit_mul_err", e, 0);
    issue(2'b11, 2'd0, 2'd3, 2'd3, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_mul_readback", d, 16'h000F);
    issue(2'b00, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0100, 0, lat, d, e);
    issue(2'b00, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0100, 0, lat, d, e);
    issue(2'b01, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_mul_overflow", d, 16'h0000);
`else
    chk("lit_mul_lat", lat, 2);
    chk("lit_mul_data", d, 16'h0000);
    chk("lit_mul_err", e, 1);
    issue(2'b11, 2'd0, 2'd3, 2'd3, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_mul_rd_kept", d, 16'hABCD);
`endif

    // Reset in the middle of an operation; the target must read back as 0
    issue(2'b00, 2'd3, 2'd0, 2'd0, 1'b1, 16'h1234, 0, lat, d, e);
    instr_valid = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
    instr = {2'b01, 2'd3, 2'd1, 2'd2, 8'h00};
    repeat (8) begin @(negedge clk); instr_valid = 1'b0; end
`else
    instr = {2'b00, 2'd3, 2'd1, 2'd2, 8'h00};
    @(negedge clk); instr_valid = 1'b0;
`endif
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_res_valid", res_valid, 0);
    issue(2'b11, 2'd0, 2'd3, 2'd3, 1'b0, 16'h0, 0, lat, d, e);
    chk("lit_post_rst_read", d, 16'h0000);

    for (int k = 0; k < 80; k++) begin
      repeat ($urandom % 3) @(negedge clk);
      issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            ($urandom % 3) == 0, 16'($urandom), int'($urandom % 4), lat, d, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
